// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 write-only LCD driver:
//   - FSM state encoding (ST_*)
//   - power-on init sequence (INIT_LEN entries, all commands with RS=0)
//   - command codes for clear / home
//   - helper that classifies a byte as a long-execution command
// ---------------------------------------------------------------------------
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP     = 3'd0,
      ST_INIT_LOAD = 3'd1,
      ST_SETUP     = 3'd2,
      ST_ENABLE    = 3'd3,
      ST_HOLD      = 3'd4,
      ST_WAIT      = 3'd5,
      ST_IDLE      = 3'd6
   } state_t;

   localparam int         INIT_LEN  = 6;
   localparam logic [7:0] LCD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_HOME  = 8'h02;

   // 8-bit bus, 2 lines, 5x8 font; display on, cursor off; entry mode increment
   localparam logic [7:0] LCD_FUNC_SET  = 8'h38;
   localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
   localparam logic [7:0] LCD_ENTRY_INC = 8'h06;

   // Init sequence: function set x3, display on, clear, entry mode
   function automatic logic [7:0] init_rom(input logic [2:0] idx);
      logic [7:0] v;
      case (idx)
         3'd0:    v = LCD_FUNC_SET;
         3'd1:    v = LCD_FUNC_SET;
         3'd2:    v = LCD_FUNC_SET;
         3'd3:    v = LCD_DISP_ON;
         3'd4:    v = LCD_CLEAR;
         3'd5:    v = LCD_ENTRY_INC;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // Clear (0x01) and home (0x02/0x03) need the long execution wait
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return (rs == 1'b0) && (data[7:2] == 6'd0) && (data != 8'h00);
   endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// ---------------------------------------------------------------------------
// lcd_delay_cnt
// Loadable down-counter shared by every timed phase of lcd_ctrl. Loading N-1
// on phase entry and leaving the phase when zero_o is seen gives exactly N
// cycles per phase. Counting stops at zero.
// Ports:
//   clk_i   in   system clock
//   rst_ni  in   async active-low reset (count <= RST_VAL)
//   load_i  in   load val_i this cycle
//   val_i   in   CNT_W-bit load value
//   zero_o  out  count is zero
// ---------------------------------------------------------------------------
module lcd_delay_cnt #(
   parameter int               CNT_W   = 20,
   parameter logic [CNT_W-1:0] RST_VAL = {CNT_W{1'b0}}
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] val_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] r_cnt;

   // Down-counter: load has priority, otherwise decrement until zero
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= RST_VAL;
      end else if (load_i) begin
         r_cnt <= val_i;
      end else if (r_cnt != {CNT_W{1'b0}}) begin
         r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign zero_o = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/lcd_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_ctrl
// Write-only HD44780 character-LCD driver. After reset it waits PWRUP_CYC,
// plays the 6-byte init sequence, then accepts one byte per valid/ready
// handshake and drives it onto the LCD pins with setup / EN pulse / hold /
// execution timing. All LCD-side outputs are registered.
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   req_valid_i/rs/data   upstream request (rs: 0 = command, 1 = data)
//   req_ready_o           request accepted on a rising edge when valid&&ready
//   init_done_o           sticky until reset once init completes
//   busy_o                ~req_ready_o
//   lcd_on_o/rs/rw/en/data  LCD pins (rw tied 0)
// ---------------------------------------------------------------------------
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int PWRUP_CYC = 750000,
   parameter int SU_CYC    = 2,
   parameter int EN_CYC    = 12,
   parameter int HOLD_CYC  = 2,
   parameter int CMD_CYC   = 2000,
   parameter int CLR_CYC   = 82000,
   parameter int CNT_W     = 20
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_valid_i,
   input  logic       req_rs_i,
   input  logic [7:0] req_data_i,
   output logic       req_ready_o,
   output logic       init_done_o,
   output logic       busy_o,
   output logic       lcd_on_o,
   output logic       lcd_rs_o,
   output logic       lcd_rw_o,
   output logic       lcd_en_o,
   output logic [7:0] lcd_data_o
);

   localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC - 1);
   localparam logic [CNT_W-1:0] SU_LD    = CNT_W'(SU_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_CYC - 1);
   localparam logic [2:0]       LAST_IDX = 3'(INIT_LEN - 1);

   state_t           r_state;
   logic [2:0]       r_idx;
   logic             r_init_done;
   logic             r_ready;
   logic             r_busy;
   logic             r_on;
   logic             r_rs;
   logic             r_en;
   logic [7:0]       r_data;

   logic             w_zero;
   logic             w_load;
   logic [CNT_W-1:0] w_val;
   logic             w_accept;

   // The counter resets to PWRUP-1 so the power-up wait starts with no extra cycle
   lcd_delay_cnt #(
      .CNT_W   (CNT_W),
      .RST_VAL (PWRUP_LD)
   ) u_delay (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (w_load),
      .val_i  (w_val),
      .zero_o (w_zero)
   );

   // Counter load for the phase being entered; the wait length is chosen from
   // the byte already latched on the pins
   always_comb begin
      w_accept = r_ready & req_valid_i;
      w_load   = 1'b0;
      w_val    = {CNT_W{1'b0}};
      case (r_state)
         ST_INIT_LOAD: begin
            w_load = 1'b1;
            w_val  = SU_LD;
         end
         ST_SETUP: begin
            if (w_zero) begin
               w_load = 1'b1;
               w_val  = EN_LD;
            end else begin
               w_load = 1'b0;
            end
         end
         ST_ENABLE: begin
            if (w_zero) begin
               w_load = 1'b1;
               w_val  = HOLD_LD;
            end else begin
               w_load = 1'b0;
            end
         end
         ST_HOLD: begin
            if (w_zero) begin
               w_load = 1'b1;
               w_val  = is_long_cmd(r_rs, r_data) ? CLR_LD : CMD_LD;
            end else begin
               w_load = 1'b0;
            end
         end
         ST_IDLE: begin
            if (w_accept) begin
               w_load = 1'b1;
               w_val  = SU_LD;
            end else begin
               w_load = 1'b0;
            end
         end
         default: begin
            w_load = 1'b0;
         end
      endcase
   end

   // Main FSM with registered LCD pins and handshake outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_PWRUP;
         r_idx       <= 3'd0;
         r_init_done <= 1'b0;
         r_ready     <= 1'b0;
         r_busy      <= 1'b1;
         r_on        <= 1'b0;
         r_rs        <= 1'b0;
         r_en        <= 1'b0;
         r_data      <= 8'h00;
      end else begin
         r_on <= 1'b1;
         case (r_state)
            ST_PWRUP: begin
               if (w_zero) r_state <= ST_INIT_LOAD;
            end
            ST_INIT_LOAD: begin
               r_rs    <= 1'b0;
               r_data  <= init_rom(r_idx);
               r_state <= ST_SETUP;
            end
            ST_SETUP: begin
               if (w_zero) begin
                  r_en    <= 1'b1;
                  r_state <= ST_ENABLE;
               end
            end
            ST_ENABLE: begin
               if (w_zero) begin
                  r_en    <= 1'b0;
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (w_zero) r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_zero) begin
                  if (!r_init_done && (r_idx != LAST_IDX)) begin
                     r_idx   <= r_idx + 3'd1;
                     r_state <= ST_INIT_LOAD;
                  end else begin
                     r_init_done <= 1'b1;
                     r_ready     <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= ST_IDLE;
                  end
               end
            end
            ST_IDLE: begin
               if (w_accept) begin
                  r_rs    <= req_rs_i;
                  r_data  <= req_data_i;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SETUP;
               end
            end
            default: begin
               r_en    <= 1'b0;
               r_ready <= 1'b0;
               r_busy  <= 1'b1;
               r_state <= ST_PWRUP;
            end
         endcase
      end
   end

   assign req_ready_o = r_ready;
   assign init_done_o = r_init_done;
   assign busy_o      = r_busy;
   assign lcd_on_o    = r_on;
   assign lcd_rs_o    = r_rs;
   assign lcd_rw_o    = 1'b0;
   assign lcd_en_o    = r_en;
   assign lcd_data_o  = r_data;

endmodule

// File: tb/tb_lcd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_ctrl
// Self-checking bench for lcd_ctrl with short timing parameters. A pin monitor
// records every EN pulse (rs, data, rise cycle) and checks pulse width, bus
// stability and rw; scenario tasks compare those records and the handshake
// timing against values computed from the LCD timing rules.
// Cycle numbering: cyc counts rising edges; values are read on falling edges.
// ---------------------------------------------------------------------------
module tb_lcd_ctrl;

   localparam int PWRUP = 100;
   localparam int SU    = 2;
   localparam int EN    = 4;
   localparam int HOLD  = 2;
   localparam int CMD   = 20;
   localparam int CLR   = 50;
   localparam int CNT_W = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_rs = 1'b0;
   logic [7:0] req_data = 8'h00;
   logic       req_ready, init_done, busy;
   logic       lcd_on, lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         rise;
   } pulse_t;
   pulse_t pulses[$];

   logic [7:0] init_seq [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

   lcd_ctrl #(
      .PWRUP_CYC (PWRUP), .SU_CYC (SU), .EN_CYC (EN), .HOLD_CYC (HOLD),
      .CMD_CYC (CMD), .CLR_CYC (CLR), .CNT_W (CNT_W)
   ) dut (
      .clk_i (clk), .rst_ni (rst_n),
      .req_valid_i (req_valid), .req_rs_i (req_rs), .req_data_i (req_data),
      .req_ready_o (req_ready), .init_done_o (init_done), .busy_o (busy),
      .lcd_on_o (lcd_on), .lcd_rs_o (lcd_rs), .lcd_rw_o (lcd_rw),
      .lcd_en_o (lcd_en), .lcd_data_o (lcd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Execution time of a byte: clear/home commands (1..3 with RS=0) are slow
   function automatic int exec_cycles(input logic rs, input logic [7:0] d);
      if (!rs && d >= 8'd1 && d <= 8'd3) return CLR;
      return CMD;
   endfunction

   // ---------------- pin monitor ----------------
   logic       m_prev_en = 1'b0;
   int         m_en_len = 0;
   int         m_hold_left = 0;
   logic       m_rs = 1'b0;
   logic [7:0] m_data = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_prev_en = 1'b0;
         m_en_len = 0;
         m_hold_left = 0;
      end else begin
         vectors++;
         if (lcd_rw !== 1'b0) begin
            miscompares++;
            $display("FAIL rw_const cyc=%0d got %b want 0", cyc, lcd_rw);
         end
         if (lcd_en === 1'b1) begin
            if (!m_prev_en) begin
               pulses.push_back('{lcd_rs, lcd_data, cyc});
               m_en_len = 1;
               m_rs = lcd_rs;
               m_data = lcd_data;
            end else begin
               m_en_len++;
               vectors++;
               if ({lcd_rs, lcd_data} !== {m_rs, m_data}) begin
                  miscompares++;
                  $display("FAIL bus_stable_en cyc=%0d got %b/%h want %b/%h", cyc, lcd_rs, lcd_data, m_rs, m_data);
               end
            end
         end else begin
            if (m_prev_en) begin
               vectors++;
               if (m_en_len != EN) begin
                  miscompares++;
                  $display("FAIL en_width cyc=%0d got %0d want %0d", cyc, m_en_len, EN);
               end
               m_hold_left = HOLD;
            end
            if (m_hold_left > 0) begin
               m_hold_left--;
               vectors++;
               if ({lcd_rs, lcd_data} !== {m_rs, m_data}) begin
                  miscompares++;
                  $display("FAIL bus_stable_hold cyc=%0d got %b/%h want %b/%h", cyc, lcd_rs, lcd_data, m_rs, m_data);
               end
            end
         end
         m_prev_en = lcd_en;
      end
   end

   // ---------------- tasks ----------------
   task automatic release_reset(output int rel);
      rst_n = 1'b1;
      rel = cyc;
      @(negedge clk);
      vectors++;
      if ({lcd_on, busy, init_done, req_ready, lcd_en} !== 5'b11000) begin
         miscompares++;
         $display("FAIL after_release on/busy/done/ready/en got %b want 11000",
                  {lcd_on, busy, init_done, req_ready, lcd_en});
      end
   endtask

   // Wait for init to finish and check the six init pulses and their timing
   task automatic test_init(input int rel, input int base);
      int k;
      int exp_rise;
      int exp_done;
      k = 0;
      while (init_done !== 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      exp_rise = rel + 1 + PWRUP + SU;
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (base + i >= pulses.size()) begin
            miscompares++;
            $display("FAIL init_pulse_missing idx=%0d got %0d pulses", i, pulses.size() - base);
         end else if (pulses[base+i].rs !== 1'b0 || pulses[base+i].data !== init_seq[i]
                      || pulses[base+i].rise != exp_rise) begin
            miscompares++;
            $display("FAIL init_pulse idx=%0d got rs=%b data=%h rise=%0d want rs=0 data=%h rise=%0d",
                     i, pulses[base+i].rs, pulses[base+i].data, pulses[base+i].rise - rel,
                     init_seq[i], exp_rise - rel);
         end
         if (i < 5) exp_rise += EN + HOLD + exec_cycles(1'b0, init_seq[i]) + 1 + SU;
      end
      exp_done = exp_rise + EN + HOLD + exec_cycles(1'b0, init_seq[5]);
      vectors++;
      if (init_done !== 1'b1 || cyc != exp_done) begin
         miscompares++;
         $display("FAIL init_done_time got done=%b at %0d want 1 at %0d", init_done, cyc - rel, exp_done - rel);
      end
      vectors++;
      if (pulses.size() - base != 6) begin
         miscompares++;
         $display("FAIL init_pulse_count got %0d want 6", pulses.size() - base);
      end
      vectors++;
      if ({req_ready, busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL ready_after_init ready/busy got %b want 10", {req_ready, busy});
      end
   endtask

   // One handshake: check ready drop, pin values, pulse, and ready return time
   task automatic send(input logic rs, input logic [7:0] d);
      int k;
      int acc;
      int pre;
      int w;
      k = 0;
      while (req_ready !== 1'b1 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (req_ready !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL send_wait_ready got ready=%b want 1", req_ready);
         return;
      end
      pre = pulses.size();
      req_valid = 1'b1;
      req_rs = rs;
      req_data = d;
      @(negedge clk);
      acc = cyc;
      req_valid = 1'b0;
      req_data = 8'($urandom_range(0, 255));
      vectors++;
      if ({req_ready, busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL ready_drop ready/busy got %b want 01", {req_ready, busy});
      end
      vectors++;
      if ({lcd_rs, lcd_data} !== {rs, d}) begin
         miscompares++;
         $display("FAIL pins_at_accept got %b/%h want %b/%h", lcd_rs, lcd_data, rs, d);
      end
      k = 0;
      while (req_ready !== 1'b1 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      w = SU + EN + HOLD + exec_cycles(rs, d);
      vectors++;
      if (req_ready !== 1'b1 || cyc - acc != w) begin
         miscompares++;
         $display("FAIL ready_return byte=%b/%h got %0d cycles want %0d", rs, d, cyc - acc, w);
      end
      vectors++;
      if (pulses.size() - pre != 1) begin
         miscompares++;
         $display("FAIL pulse_count byte=%b/%h got %0d want 1", rs, d, pulses.size() - pre);
      end else if (pulses[pre].rs !== rs || pulses[pre].data !== d || pulses[pre].rise != acc + SU) begin
         miscompares++;
         $display("FAIL pulse byte got rs=%b data=%h rise=+%0d want rs=%b data=%h rise=+%0d",
                  pulses[pre].rs, pulses[pre].data, pulses[pre].rise - acc, rs, d, SU);
      end
      vectors++;
      if ({lcd_rs, lcd_data} !== {rs, d}) begin
         miscompares++;
         $display("FAIL pins_idle_keep got %b/%h want %b/%h", lcd_rs, lcd_data, rs, d);
      end
   endtask

   task automatic test_reset;
      int rel;
      int base;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({lcd_on, lcd_rs, lcd_rw, lcd_en, lcd_data, req_ready, init_done, busy} !== 15'b000000000000001) begin
         miscompares++;
         $display("FAIL reset_state got on=%b rs=%b rw=%b en=%b data=%h ready=%b done=%b busy=%b want all 0 busy=1",
                  lcd_on, lcd_rs, lcd_rw, lcd_en, lcd_data, req_ready, init_done, busy);
      end
      base = pulses.size();
      release_reset(rel);
      test_init(rel, base);
   endtask

   task automatic test_data_write;
      send(1'b1, 8'h41);
   endtask

   task automatic test_long_cmds;
      send(1'b0, 8'h01);
      send(1'b0, 8'h80);
      send(1'b0, 8'h02);
      send(1'b0, 8'h03);
      send(1'b0, 8'h00);
      send(1'b0, 8'h04);
      send(1'b1, 8'h01);
   endtask

   task automatic test_random;
      logic [7:0] d;
      for (int i = 0; i < 12; i++) begin
         d = (($urandom & 32'd3) == 32'd0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
         send(1'($urandom), d);
      end
   endtask

   // Valid held through init and through a busy period: each byte goes out once
   task automatic test_back_to_back;
      int rel;
      int base;
      int r1;
      int r2;
      int k;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      req_valid = 1'b1;
      req_rs = 1'b1;
      req_data = 8'h48;
      base = pulses.size();
      release_reset(rel);
      test_init(rel, base);
      r1 = cyc;
      @(negedge clk);
      req_data = 8'h69;
      k = 0;
      while (req_ready !== 1'b1 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      r2 = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (150) @(negedge clk);
      vectors++;
      if (r2 - r1 != 1 + SU + EN + HOLD + exec_cycles(1'b1, 8'h48)) begin
         miscompares++;
         $display("FAIL b2b_ready_gap got %0d want %0d", r2 - r1, 1 + SU + EN + HOLD + CMD);
      end
      vectors++;
      if (pulses.size() - base != 8) begin
         miscompares++;
         $display("FAIL b2b_pulse_count got %0d want 8", pulses.size() - base);
      end else if (pulses[base+6].data !== 8'h48 || pulses[base+6].rise != r1 + 1 + SU
                   || pulses[base+7].data !== 8'h69 || pulses[base+7].rise != r2 + 1 + SU) begin
         miscompares++;
         $display("FAIL b2b_pulses got %h@%0d %h@%0d want 48@%0d 69@%0d",
                  pulses[base+6].data, pulses[base+6].rise, pulses[base+7].data, pulses[base+7].rise,
                  r1 + 1 + SU, r2 + 1 + SU);
      end
   endtask

   task automatic test_reset_mid_op;
      int rel;
      int base;
      int k;
      k = 0;
      while (req_ready !== 1'b1 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      req_valid = 1'b1;
      req_rs = 1'b1;
      req_data = 8'h5A;
      @(negedge clk);
      req_valid = 1'b0;
      k = 0;
      while (lcd_en !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      vectors++;
      if (lcd_en !== 1'b1) begin
         miscompares++;
         $display("FAIL midop_en_seen got en=%b want 1", lcd_en);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({lcd_en, busy, init_done, req_ready} !== 4'b0100) begin
         miscompares++;
         $display("FAIL midop_async_reset en/busy/done/ready got %b want 0100",
                  {lcd_en, busy, init_done, req_ready});
      end
      repeat (3) @(negedge clk);
      base = pulses.size();
      release_reset(rel);
      test_init(rel, base);
   endtask

   initial begin
      test_reset();
      test_data_write();
      test_long_cmds();
      test_random();
      test_back_to_back();
      test_reset_mid_op();
      send(1'b1, 8'h7E);
      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
